// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared encodings and state type for the IF stage
package fetch_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  // ECALL/EBREAK stop fetch after they have been handed to decode
  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/fetch_stage_instr_mem.sv
// rtl/fetch_stage_instr_mem.sv - instruction memory with combinational read
module fetch_stage_instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] memory [0:DEPTH-1];

  // Preload port; contents may also be placed directly into memory[] before run
  always_ff @(posedge clk) begin
    if (wr_en) begin
      memory[wr_addr] <= wr_data;
    end
  end

  assign rd_data = memory[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, instruction fetch, IF/ID register, RUN/HALTED control
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [31:0]     if_id_instr_o,
  output logic            halted_o,
  output logic            fetch_fault_o
);

  localparam int              AW          = $clog2(IMEM_DEPTH);
  localparam logic [XLEN-3:0] DEPTH_WORDS = (XLEN-2)'(IMEM_DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_plus4;
  logic [31:0]     fetch_word;
  logic            in_range;
  logic            unused_redirect_lsbs;

  assign pc_plus4 = pc_o + XLEN'(4);
  assign in_range = (pc_o[XLEN-1:2] < DEPTH_WORDS);

  // Targets are forced to word alignment; the low bits carry no information here
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  fetch_stage_instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) instr_mem (
    .clk     (clk),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_data ('0),
    .rd_addr (pc_o[AW+1:2]),
    .rd_data (fetch_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_o          <= RESET_PC;
      if_id_valid_o <= 1'b0;
      if_id_pc_o    <= '0;
      if_id_pc4_o   <= '0;
      if_id_instr_o <= INSTR_NOP;
      state         <= FETCH_RUN;
      halted_o      <= 1'b0;
      fetch_fault_o <= 1'b0;
    end else if (redirect_i) begin
      // Redirect wins over stall and over HALTED; the sticky fault survives it
      pc_o          <= {redirect_pc_i[XLEN-1:2], 2'b00};
      if_id_valid_o <= 1'b0;
      if_id_pc_o    <= '0;
      if_id_pc4_o   <= '0;
      if_id_instr_o <= INSTR_NOP;
      state         <= FETCH_RUN;
      halted_o      <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        FETCH_RUN: begin
          if (in_range) begin
            if_id_valid_o <= 1'b1;
            if_id_pc_o    <= pc_o;
            if_id_pc4_o   <= pc_plus4;
            if_id_instr_o <= fetch_word;
            pc_o          <= pc_plus4;
            if (is_halt_instr(fetch_word)) begin
              state    <= FETCH_HALTED;
              halted_o <= 1'b1;
            end
          end else begin
            if_id_valid_o <= 1'b0;
            if_id_pc_o    <= '0;
            if_id_pc4_o   <= '0;
            if_id_instr_o <= INSTR_NOP;
            fetch_fault_o <= 1'b1;
            state         <= FETCH_HALTED;
            halted_o      <= 1'b1;
          end
        end
        FETCH_HALTED: begin
          if_id_valid_o <= 1'b0;
          if_id_pc_o    <= '0;
          if_id_pc4_o   <= '0;
          if_id_instr_o <= INSTR_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] ifpc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        halt;
    logic        fault;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] a_pc, a_ifpc, a_pc4, a_instr;
  logic        a_valid, a_halt, a_fault;
  logic [31:0] b_pc, b_ifpc, b_pc4, b_instr;
  logic        b_valid, b_halt, b_fault;

  fetch_stage #(.XLEN(32), .IMEM_DEPTH(256), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (a_pc),
    .if_id_valid_o (a_valid),
    .if_id_pc_o    (a_ifpc),
    .if_id_pc4_o   (a_pc4),
    .if_id_instr_o (a_instr),
    .halted_o      (a_halt),
    .fetch_fault_o (a_fault)
  );

  fetch_stage #(.XLEN(32), .IMEM_DEPTH(8), .RESET_PC(32'h0)) dut8 (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (b_pc),
    .if_id_valid_o (b_valid),
    .if_id_pc_o    (b_ifpc),
    .if_id_pc4_o   (b_pc4),
    .if_id_instr_o (b_instr),
    .halted_o      (b_halt),
    .fetch_fault_o (b_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        sel8 = 1'b0;
  logic [31:0] bmem  [0:255];
  logic [31:0] bmem8 [0:7];
  obs_t        m, e;
  obs_t        obs, obs_a, obs_b, rst_obs;
  obs_t        exp_q[$];

  assign obs_a   = {a_valid, a_ifpc, a_pc4, a_instr, a_pc, a_halt, a_fault};
  assign obs_b   = {b_valid, b_ifpc, b_pc4, b_instr, b_pc, b_halt, b_fault};
  assign obs     = sel8 ? obs_b : obs_a;
  assign rst_obs = {1'b0, 32'h0, 32'h0, INSTR_NOP, 32'h0, 1'b0, 1'b0};

  task automatic model_reset;
    m = rst_obs;
    exp_q.delete();
  endtask

  task automatic do_reset;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #4;
    model_reset();
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs, push the expected post-edge view, wait past the edge
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    int unsigned wi;
    logic [31:0] w;
    stall = st; redirect = rd; redirect_pc = tgt;
    if (rd) begin
      m.pc = {tgt[31:2], 2'b00};
      m.valid = 1'b0; m.ifpc = 32'h0; m.pc4 = 32'h0; m.instr = INSTR_NOP;
      m.halt = 1'b0;
    end else if (!st) begin
      if (m.halt) begin
        m.valid = 1'b0; m.ifpc = 32'h0; m.pc4 = 32'h0; m.instr = INSTR_NOP;
      end else begin
        wi = m.pc >> 2;
        if (wi < (sel8 ? 32'd8 : 32'd256)) begin
          w = sel8 ? bmem8[wi[2:0]] : bmem[wi[7:0]];
          m.valid = 1'b1; m.ifpc = m.pc; m.pc4 = m.pc + 32'd4; m.instr = w;
          m.pc = m.pc + 32'd4;
          if (w == 32'h0000_0073 || w == 32'h0010_0073) m.halt = 1'b1;
        end else begin
          m.valid = 1'b0; m.ifpc = 32'h0; m.pc4 = 32'h0; m.instr = INSTR_NOP;
          m.fault = 1'b1; m.halt = 1'b1;
        end
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #2;
    checks++;
    if (obs_a !== rst_obs) begin errors++; $display("FAIL reset_256: got %h want %h", obs_a, rst_obs); end
    checks++;
    if (obs_b !== rst_obs) begin errors++; $display("FAIL reset_8: got %h want %h", obs_b, rst_obs); end
    redirect = 1'b1; redirect_pc = 32'h40;
    @(posedge clk);
    #2;
    checks++;
    if (obs_a !== rst_obs) begin errors++; $display("FAIL reset_hold: got %h want %h", obs_a, rst_obs); end
    redirect = 1'b0;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_straight_line;
    repeat (3) begin
      step(1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL straight_line: got %h want %h", obs, e); end
    end
    checks++;
    if (a_ifpc !== 32'h8 || a_pc4 !== 32'hC || a_instr !== 32'h002081b3 || a_valid !== 1'b1) begin
      errors++; $display("FAIL straight_third: got pc=%h pc4=%h instr=%h v=%b want 8/c/002081b3/1", a_ifpc, a_pc4, a_instr, a_valid);
    end
  endtask

  task automatic test_stall;
    do_reset();
    repeat (2) begin
      step(1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL stall_pre: got %h want %h", obs, e); end
    end
    repeat (2) begin
      step(1'b1, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL stall_hold: got %h want %h", obs, e); end
      checks++;
      if (a_pc !== 32'h8 || a_ifpc !== 32'h4 || a_valid !== 1'b1) begin
        errors++; $display("FAIL stall_const: got pc=%h ifpc=%h v=%b want 8/4/1", a_pc, a_ifpc, a_valid);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_resume: got %h want %h", obs, e); end
    checks++;
    if (a_ifpc !== 32'h8) begin errors++; $display("FAIL stall_resume_pc: got %h want 8", a_ifpc); end
  endtask

  task automatic test_redirect_stall;
    step(1'b1, 1'b1, 32'h0000_001E);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL redirect_stall: got %h want %h", obs, e); end
    checks++;
    if (a_pc !== 32'h1C || a_valid !== 1'b0 || a_instr !== INSTR_NOP) begin
      errors++; $display("FAIL redirect_const: got pc=%h v=%b instr=%h want 1c/0/00000013", a_pc, a_valid, a_instr);
    end
    step(1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL redirect_next: got %h want %h", obs, e); end
    checks++;
    if (a_ifpc !== 32'h1C) begin errors++; $display("FAIL redirect_next_pc: got %h want 1c", a_ifpc); end
  endtask

  task automatic test_ecall;
    step(1'b0, 1'b1, 32'h0000_000C);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ecall_redir: got %h want %h", obs, e); end
    repeat (3) begin
      step(1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ecall_run: got %h want %h", obs, e); end
    end
    checks++;
    if (a_instr !== 32'h73 || a_ifpc !== 32'h14 || a_halt !== 1'b1 || a_pc !== 32'h18) begin
      errors++; $display("FAIL ecall_const: got instr=%h ifpc=%h halt=%b pc=%h want 73/14/1/18", a_instr, a_ifpc, a_halt, a_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ecall_bubble: got %h want %h", obs, e); end
    end
    step(1'b0, 1'b1, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ecall_resume: got %h want %h", obs, e); end
    checks++;
    if (a_halt !== 1'b0 || a_pc !== 32'h0) begin errors++; $display("FAIL ecall_resume_const: got halt=%b pc=%h want 0/0", a_halt, a_pc); end
    step(1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ecall_restart: got %h want %h", obs, e); end
    step(1'b0, 1'b1, 32'h0000_0024);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ebreak_redir: got %h want %h", obs, e); end
    step(1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ebreak_fetch: got %h want %h", obs, e); end
    checks++;
    if (a_instr !== 32'h0010_0073 || a_halt !== 1'b1 || a_pc !== 32'h28) begin
      errors++; $display("FAIL ebreak_const: got instr=%h halt=%b pc=%h want 00100073/1/28", a_instr, a_halt, a_pc);
    end
  endtask

  task automatic test_fault;
    sel8 = 1'b1;
    do_reset();
    repeat (10) begin
      step(1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fault_run: got %h want %h", obs, e); end
    end
    checks++;
    if (b_fault !== 1'b1 || b_halt !== 1'b1 || b_valid !== 1'b0 || b_pc !== 32'h20) begin
      errors++; $display("FAIL fault_const: got fault=%b halt=%b v=%b pc=%h want 1/1/0/20", b_fault, b_halt, b_valid, b_pc);
    end
    step(1'b0, 1'b1, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL fault_redir: got %h want %h", obs, e); end
    checks++;
    if (b_fault !== 1'b1 || b_halt !== 1'b0) begin errors++; $display("FAIL fault_sticky: got fault=%b halt=%b want 1/0", b_fault, b_halt); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 12 && !m.halt; i++) begin
      step(1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL async_run: got %h want %h", obs, e); end
    end
    checks++;
    if (b_halt !== 1'b1 || b_fault !== 1'b1) begin errors++; $display("FAIL async_pre: got halt=%b fault=%b want 1/1", b_halt, b_fault); end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs_b !== rst_obs) begin errors++; $display("FAIL async_reset_8: got %h want %h", obs_b, rst_obs); end
    checks++;
    if (obs_a !== rst_obs) begin errors++; $display("FAIL async_reset_256: got %h want %h", obs_a, rst_obs); end
    #2;
    model_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL async_restart: got %h want %h", obs, e); end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) bmem[i] = 32'h0000_0093 + (i << 20);
    bmem[0] = 32'h0050_0093;
    bmem[1] = 32'h0030_0113;
    bmem[2] = 32'h0020_81b3;
    bmem[5] = 32'h0000_0073;
    bmem[9] = 32'h0010_0073;
    for (int i = 0; i < 8; i++) bmem8[i] = 32'h0000_0113 + (i << 20);
    for (int i = 0; i < 256; i++) dut.instr_mem.memory[i] = bmem[i];
    for (int i = 0; i < 8; i++) dut8.instr_mem.memory[i] = bmem8[i];

    test_reset();
    test_straight_line();
    test_stall();
    test_redirect_stall();
    test_ecall();
    test_fault();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
